// File: rtl/sound_glu.sv
// CPU-side GLU front end for the Ensoniq DOC: auto-increment pointer, busy flag,
// one-read-behind data latch, and sound RAM arbitration with DOC fetch priority.
module sound_glu #(
    parameter int          RAM_AW        = 16,
    parameter logic [7:0]  IDLE_DOC_ADDR = 8'hE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_sel,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              doc_wr,
    output logic [7:0]        doc_reg_addr,
    output logic [7:0]        doc_reg_data,
    input  logic [7:0]        doc_data_out,
    input  logic              doc_osc_en,
    input  logic [RAM_AW-1:0] doc_fetch_addr,
    output logic [7:0]        doc_sample_out,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic [3:0]        master_vol,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [6:0]          ctrl_q, ctrl_d;
    logic [RAM_AW-1:0]   ptr_q, ptr_d;
    logic [7:0]          latch_q, latch_d;
    logic [RAM_AW-1:0]   tgt_q, tgt_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                ram_mode_q, ram_mode_d;
    logic [7:0]          sample_q, sample_d;
    logic                fetch_vld_q, fetch_vld_d;

    logic [15:0]         ptr_ext;
    logic                accept;
    logic                issue_ram;
    logic                issue_doc;

    always_comb begin
        ptr_ext = 16'(ptr_q);
        busy    = (state_q != S_IDLE);
        accept  = cpu_sel && (cpu_addr == 2'd1) && !busy;

        state_d     = state_q;
        ctrl_d      = ctrl_q;
        ptr_d       = ptr_q;
        latch_d     = latch_q;
        tgt_d       = tgt_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        ram_mode_d  = ram_mode_q;
        fetch_vld_d = doc_osc_en;
        sample_d    = fetch_vld_q ? ram_dout : sample_q;

        // Control and pointer writes are honoured regardless of busy.
        if (cpu_sel && cpu_wr) begin
            case (cpu_addr)
                2'd0: ctrl_d = cpu_din[6:0];
                2'd2: ptr_d  = RAM_AW'({ptr_ext[15:8], cpu_din});
                2'd3: ptr_d  = RAM_AW'({cpu_din, ptr_ext[7:0]});
                default: ;
            endcase
        end

        // Mode is frozen at the strobe so a later ctrl write cannot retarget it.
        if (accept) begin
            state_d    = S_PEND;
            wr_d       = cpu_wr;
            wdata_d    = cpu_din;
            ram_mode_d = ctrl_q[6];
            tgt_d      = ctrl_q[6] ? ptr_q : {{(RAM_AW-8){1'b0}}, ptr_q[7:0]};
            if (ctrl_q[5]) begin
                if (ctrl_q[6]) ptr_d = ptr_q + RAM_AW'(1);
                else           ptr_d[7:0] = ptr_q[7:0] + 8'd1;
            end
        end

        issue_ram = (state_q == S_PEND) && ram_mode_q && !doc_osc_en && !reset;
        issue_doc = (state_q == S_PEND) && !ram_mode_q && !reset;

        case (state_q)
            S_PEND: begin
                if (issue_ram || issue_doc) state_d = wr_q ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                latch_d = ram_mode_q ? ram_dout : doc_data_out;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // DOC oscillator fetch always wins the RAM port.
        if (doc_osc_en)     ram_addr = doc_fetch_addr;
        else if (issue_ram) ram_addr = tgt_q;
        else                ram_addr = '0;
        ram_we       = issue_ram && wr_q;
        ram_din      = wdata_q;
        doc_wr       = issue_doc && wr_q;
        doc_reg_addr = issue_doc ? tgt_q[7:0] : IDLE_DOC_ADDR;
        doc_reg_data = wdata_q;

        case (cpu_addr)
            2'd0:    cpu_dout = {busy, ctrl_q};
            2'd1:    cpu_dout = latch_q;
            2'd2:    cpu_dout = ptr_ext[7:0];
            default: cpu_dout = ptr_ext[15:8];
        endcase
    end

    assign master_vol     = ctrl_q[3:0];
    assign doc_sample_out = sample_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            ptr_q       <= '0;
            latch_q     <= '0;
            tgt_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            ram_mode_q  <= 1'b0;
            sample_q    <= '0;
            fetch_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            ptr_q       <= ptr_d;
            latch_q     <= latch_d;
            tgt_q       <= tgt_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            ram_mode_q  <= ram_mode_d;
            sample_q    <= sample_d;
            fetch_vld_q <= fetch_vld_d;
        end
    end

endmodule
